// File: rtl/buzzer_sched.sv
// Fixed-priority scheduler for the shared buzzer driver. Grants one tone requester at a time,
// latches its compare value and beep count, then plays a burst of on/off beeps before
// pulsing done back to the owner. Index 0 has the highest priority. All outputs are registered.
module buzzer_sched #(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned CMP_W     = 22,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned TIME_W    = 24,
  parameter int unsigned ON_TICKS  = 12500000,
  parameter int unsigned OFF_TICKS = 12500000
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*CMP_W-1:0] cmp_req_i,
  input  logic [N_REQ*CNT_W-1:0] beeps_req_i,
  input  logic                   sil_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       done_o,
  output logic                   busy_o,
  output logic                   buzzer_en_o,
  output logic [CMP_W-1:0]       cmp_o
);

  localparam logic [TIME_W-1:0] OnLast  = TIME_W'(ON_TICKS - 1);
  localparam logic [TIME_W-1:0] OffLast = TIME_W'(OFF_TICKS - 1);

  // StGnt is the single visible grant cycle of a zero-count request, ahead of its done pulse.
  typedef enum logic [2:0] {StIdle, StGnt, StOn, StOff, StDone} state_e;

  state_e              state_q, state_d;
  logic [N_REQ-1:0]    owner_q, owner_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [TIME_W-1:0]   timer_q, timer_d;
  logic [CMP_W-1:0]    cmp_q, cmp_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic                busy_q, busy_d;
  logic                en_q, en_d;

  logic [N_REQ-1:0]    pick;
  logic [CMP_W-1:0]    pick_cmp;
  logic [CNT_W-1:0]    pick_beeps;
  logic                abandon;

  // Lowest set request index wins; scanning downward lets the lowest index overwrite.
  always_comb begin
    pick       = '0;
    pick_cmp   = '0;
    pick_beeps = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        pick       = '0;
        pick[i]    = 1'b1;
        pick_cmp   = cmp_req_i[i*CMP_W +: CMP_W];
        pick_beeps = beeps_req_i[i*CNT_W +: CNT_W];
      end
    end
  end

  assign abandon = ((req_i & owner_q) == '0);

  // Next-state and datapath: silence beats abandon, abandon beats timer expiry.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rem_d   = rem_q;
    timer_d = timer_q;
    cmp_d   = cmp_q;
    if (sil_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req_i) begin
            owner_d = pick;
            cmp_d   = pick_cmp;
            rem_d   = pick_beeps;
            timer_d = '0;
            state_d = (pick_beeps == '0) ? StGnt : StOn;
          end
        end
        StGnt: state_d = StDone;
        StOn: begin
          if (abandon) begin
            state_d = StIdle;
          end else if (timer_q == OnLast) begin
            rem_d   = rem_q - CNT_W'(1);
            timer_d = '0;
            state_d = (rem_q == CNT_W'(1)) ? StDone : StOff;
          end else begin
            timer_d = timer_q + TIME_W'(1);
          end
        end
        StOff: begin
          if (abandon) begin
            state_d = StIdle;
          end else if (timer_q == OffLast) begin
            timer_d = '0;
            state_d = StOn;
          end else begin
            timer_d = timer_q + TIME_W'(1);
          end
        end
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state once registered.
  always_comb begin
    busy_d = (state_d != StIdle);
    en_d   = (state_d == StOn);
    gnt_d  = (state_d == StOn || state_d == StOff || state_d == StGnt) ? owner_d : '0;
    done_d = (state_d == StDone) ? owner_d : '0;
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      owner_q <= '0;
      rem_q   <= '0;
      timer_q <= '0;
      cmp_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rem_q   <= rem_d;
      timer_q <= timer_d;
      cmp_q   <= cmp_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign busy_o      = busy_q;
  assign buzzer_en_o = en_q;
  assign cmp_o       = cmp_q;

endmodule

// File: tb/tb_buzzer_sched.sv
// Bench for buzzer_sched with short on/off times. Each scenario pushes the expected per-cycle
// output vector {gnt, done, busy, en, cmp} to a queue, then pops one entry per clock and compares.
module tb_buzzer_sched;

  localparam int unsigned N_REQ     = 3;
  localparam int unsigned CMP_W     = 22;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned TIME_W    = 24;
  localparam int unsigned ON_TICKS  = 4;
  localparam int unsigned OFF_TICKS = 3;

  typedef logic [2*N_REQ+2+CMP_W-1:0] vec_t;

  logic                   clk;
  logic                   rst_n;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*CMP_W-1:0] cmp_req;
  logic [N_REQ*CNT_W-1:0] beeps_req;
  logic                   sil;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic                   en;
  logic [CMP_W-1:0]       cmp;

  int checks = 0;
  int errors = 0;
  vec_t exp_q[$];

  buzzer_sched #(
    .N_REQ    (N_REQ),
    .CMP_W    (CMP_W),
    .CNT_W    (CNT_W),
    .TIME_W   (TIME_W),
    .ON_TICKS (ON_TICKS),
    .OFF_TICKS(OFF_TICKS)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .req_i      (req),
    .cmp_req_i  (cmp_req),
    .beeps_req_i(beeps_req),
    .sil_i      (sil),
    .gnt_o      (gnt),
    .done_o     (done),
    .busy_o     (busy),
    .buzzer_en_o(en),
    .cmp_o      (cmp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic [N_REQ-1:0] g, logic [N_REQ-1:0] d, logic b, logic e,
                              logic [CMP_W-1:0] c);
    return {g, d, b, e, c};
  endfunction

  task automatic push(vec_t v, int n);
    repeat (n) exp_q.push_back(v);
  endtask

  // Expected trace of an n-beep burst (n >= 1), its done cycle and the following idle cycle.
  task automatic push_burst(logic [N_REQ-1:0] g, logic [CMP_W-1:0] c, int n);
    for (int b = 1; b <= n; b++) begin
      push(mk(g, '0, 1'b1, 1'b1, c), ON_TICKS);
      if (b < n) push(mk(g, '0, 1'b1, 1'b0, c), OFF_TICKS);
    end
    push(mk('0, g, 1'b1, 1'b0, c), 1);
    push(mk('0, '0, 1'b0, 1'b0, c), 1);
  endtask

  task automatic set_src(int i, logic [CMP_W-1:0] c, logic [CNT_W-1:0] n);
    cmp_req[i*CMP_W +: CMP_W]   = c;
    beeps_req[i*CNT_W +: CNT_W] = n;
  endtask

  task automatic test_reset();
    vec_t e, o;
    rst_n = 1'b0;
    req   = 3'b111;
    sil   = 1'b0;
    set_src(0, 22'h00123, 4'd1);
    set_src(1, 22'h00456, 4'd1);
    set_src(2, 22'h00789, 4'd1);
    push(mk('0, '0, 1'b0, 1'b0, '0), 4);
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = {gnt, done, busy, en, cmp};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset cyc %0d: got %h expected %h", k, o, e);
      end
      if (k == 2) begin
        req   = '0;
        rst_n = 1'b1;
      end
    end
  endtask

  task automatic test_single_burst();
    vec_t e, o;
    set_src(1, 22'h01000, 4'd2);
    req = 3'b010;
    push_burst(3'b010, 22'h01000, 2);
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = {gnt, done, busy, en, cmp};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL single_burst cyc %0d: got %h expected %h", k, o, e);
      end
      req = req & ~e[CMP_W+2 +: N_REQ];
      // Inputs changed after grant must not affect the running burst.
      if (k == 0) set_src(1, 22'h3ffff, 4'd5);
    end
  endtask

  task automatic test_simultaneous();
    vec_t e, o;
    set_src(0, 22'h00aaa, 4'd1);
    set_src(2, 22'h00bbb, 4'd1);
    req = 3'b101;
    push_burst(3'b001, 22'h00aaa, 1);
    push_burst(3'b100, 22'h00bbb, 1);
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = {gnt, done, busy, en, cmp};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL simultaneous cyc %0d: got %h expected %h", k, o, e);
      end
      req = req & ~e[CMP_W+2 +: N_REQ];
    end
  endtask

  task automatic test_no_preempt();
    vec_t e, o;
    set_src(0, 22'h00c0c, 4'd1);
    set_src(2, 22'h00d0d, 4'd1);
    req = 3'b100;
    push_burst(3'b100, 22'h00d0d, 1);
    push_burst(3'b001, 22'h00c0c, 1);
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = {gnt, done, busy, en, cmp};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL no_preempt cyc %0d: got %h expected %h", k, o, e);
      end
      req = req & ~e[CMP_W+2 +: N_REQ];
      if (k == 0) req[0] = 1'b1;
    end
  endtask

  task automatic test_abort_sil();
    vec_t e, o;
    set_src(1, 22'h02468, 4'd2);
    req = 3'b010;
    push(mk(3'b010, '0, 1'b1, 1'b1, 22'h02468), ON_TICKS);
    push(mk(3'b010, '0, 1'b1, 1'b0, 22'h02468), 1);
    push(mk('0, '0, 1'b0, 1'b0, 22'h02468), 2);
    push_burst(3'b010, 22'h02468, 2);
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = {gnt, done, busy, en, cmp};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL abort_sil cyc %0d: got %h expected %h", k, o, e);
      end
      req = req & ~e[CMP_W+2 +: N_REQ];
      if (k == ON_TICKS) sil = 1'b1;
      if (k == ON_TICKS + 2) sil = 1'b0;
    end
  endtask

  task automatic test_abort_drop();
    vec_t e, o;
    set_src(2, 22'h13579, 4'd3);
    req = 3'b100;
    push(mk(3'b100, '0, 1'b1, 1'b1, 22'h13579), 2);
    push(mk('0, '0, 1'b0, 1'b0, 22'h13579), 2);
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = {gnt, done, busy, en, cmp};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL abort_drop cyc %0d: got %h expected %h", k, o, e);
      end
      if (k == 1) req = '0;
    end
  endtask

  task automatic test_zero_count();
    vec_t e, o;
    set_src(0, 22'h0beef, 4'd0);
    req = 3'b001;
    push(mk(3'b001, '0, 1'b1, 1'b0, 22'h0beef), 1);
    push(mk('0, 3'b001, 1'b1, 1'b0, 22'h0beef), 1);
    push(mk('0, '0, 1'b0, 1'b0, 22'h0beef), 2);
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = {gnt, done, busy, en, cmp};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL zero_count cyc %0d: got %h expected %h", k, o, e);
      end
      req = req & ~e[CMP_W+2 +: N_REQ];
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    sil       = 1'b0;
    cmp_req   = '0;
    beeps_req = '0;
    test_reset();
    test_single_burst();
    test_simultaneous();
    test_no_preempt();
    test_abort_sil();
    test_abort_drop();
    test_zero_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
